// File: rtl/alu_writeback_unit.sv
// Writeback stage for the 8-bit ALU: commits NZCV flags, drives register-file writes
// (XCHG as two writes), resolves branches. Optional macro WB_R0_PROTECT_EN suppresses writes to r0.
module alu_writeback_unit #(
   parameter int DATA_W = 8,
   parameter int REG_AW = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        ALUControl,
   input  logic [DATA_W-1:0] ALUResult,
   input  logic [DATA_W-1:0] ALUResult2,
   input  logic [3:0]        ALUFlags,
   input  logic [REG_AW-1:0] rd_a,
   input  logic [REG_AW-1:0] rd_b,
   input  logic [3:0]        cond,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic [3:0]        flags_q,
   output logic              branch_taken,
   output logic [DATA_W-1:0] branch_target
);

   typedef enum logic [0:0] {
      S_RUN   = 1'b0,
      S_XCHG2 = 1'b1
   } state_t;

   localparam logic [4:0] OP_NOP  = 5'h00;
   localparam logic [4:0] OP_XCHG = 5'h07;
   localparam logic [4:0] OP_CMP  = 5'h14;
   localparam logic [4:0] OP_BR   = 5'h1F;

   state_t              state_q, state_d;
   logic                rf_we_q, rf_we_d;
   logic [REG_AW-1:0]   rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
   logic [3:0]          flags_d;
   logic                branch_taken_q, branch_taken_d;
   logic [DATA_W-1:0]   branch_target_q, branch_target_d;
   logic [REG_AW-1:0]   rd_b_q, rd_b_d;
   logic [DATA_W-1:0]   res2_q, res2_d;
   logic                accept_s;
   logic                wr_ok_a_s;
   logic                wr_ok_b_s;

   function automatic logic op_writes_flags(input logic [4:0] op);
      logic r;
      case (op)
         5'h01, 5'h02, 5'h03, 5'h04, 5'h05,
         5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F, 5'h10,
         5'h14:   r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic op_writes_reg(input logic [4:0] op);
      logic r;
      case (op)
         OP_NOP, OP_CMP, OP_BR: r = 1'b0;
         default:               r = 1'b1;
      endcase
      return r;
   endfunction

   function automatic logic cond_true(input logic [3:0] cc, input logic [3:0] f);
      logic n, z, c, v, r;
      {n, z, c, v} = f;
      case (cc)
         4'h0:    r = 1'b1;
         4'h1:    r = z;
         4'h2:    r = ~z;
         4'h3:    r = c;
         4'h4:    r = ~c;
         4'h5:    r = n;
         4'h6:    r = ~n;
         4'h7:    r = v;
         4'h8:    r = ~v;
         4'h9:    r = ~(n ^ v);
         4'hA:    r = n ^ v;
         4'hB:    r = ~z & ~(n ^ v);
         4'hC:    r = z | (n ^ v);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

`ifdef WB_R0_PROTECT_EN
   assign wr_ok_a_s = (rd_a   != {REG_AW{1'b0}});
   assign wr_ok_b_s = (rd_b_q != {REG_AW{1'b0}});
`else
   assign wr_ok_a_s = 1'b1;
   assign wr_ok_b_s = 1'b1;
`endif

   assign in_ready      = (state_q == S_RUN);
   assign accept_s      = in_valid && in_ready;
   assign rf_we         = rf_we_q;
   assign rf_waddr      = rf_waddr_q;
   assign rf_wdata      = rf_wdata_q;
   assign branch_taken  = branch_taken_q;
   assign branch_target = branch_target_q;

   // Next-state and next-output computation; address/data/target hold unless a new effect lands.
   always_comb begin
      state_d         = state_q;
      rf_we_d         = 1'b0;
      rf_waddr_d      = rf_waddr_q;
      rf_wdata_d      = rf_wdata_q;
      flags_d         = flags_q;
      branch_taken_d  = 1'b0;
      branch_target_d = branch_target_q;
      rd_b_d          = rd_b_q;
      res2_d          = res2_q;
      case (state_q)
         S_RUN: begin
            if (accept_s) begin
               if (op_writes_reg(ALUControl) && wr_ok_a_s) begin
                  rf_we_d    = 1'b1;
                  rf_waddr_d = rd_a;
                  rf_wdata_d = ALUResult;
               end else begin
                  rf_we_d    = 1'b0;
               end
               if (op_writes_flags(ALUControl)) begin
                  flags_d = ALUFlags;
               end else begin
                  flags_d = flags_q;
               end
               // Branch reads the committed flags; it never writes them, so no bypass exists.
               if ((ALUControl == OP_BR) && cond_true(cond, flags_q)) begin
                  branch_taken_d  = 1'b1;
                  branch_target_d = ALUResult;
               end else begin
                  branch_taken_d  = 1'b0;
               end
               if (ALUControl == OP_XCHG) begin
                  state_d = S_XCHG2;
                  rd_b_d  = rd_b;
                  res2_d  = ALUResult2;
               end else begin
                  state_d = S_RUN;
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_XCHG2: begin
            state_d = S_RUN;
            if (wr_ok_b_s) begin
               rf_we_d    = 1'b1;
               rf_waddr_d = rd_b_q;
               rf_wdata_d = res2_q;
            end else begin
               rf_we_d    = 1'b0;
            end
         end
         default: begin
            state_d = S_RUN;
         end
      endcase
   end

   // State and output registers; reset discards any pending XCHG second write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_RUN;
         rf_we_q         <= 1'b0;
         rf_waddr_q      <= {REG_AW{1'b0}};
         rf_wdata_q      <= {DATA_W{1'b0}};
         flags_q         <= 4'b0000;
         branch_taken_q  <= 1'b0;
         branch_target_q <= {DATA_W{1'b0}};
         rd_b_q          <= {REG_AW{1'b0}};
         res2_q          <= {DATA_W{1'b0}};
      end else begin
         state_q         <= state_d;
         rf_we_q         <= rf_we_d;
         rf_waddr_q      <= rf_waddr_d;
         rf_wdata_q      <= rf_wdata_d;
         flags_q         <= flags_d;
         branch_taken_q  <= branch_taken_d;
         branch_target_q <= branch_target_d;
         rd_b_q          <= rd_b_d;
         res2_q          <= res2_d;
      end
   end

endmodule

// File: tb/tb_alu_writeback_unit.sv
// Scoreboard bench for alu_writeback_unit: driver pushes expected writes, branches and
// flag states stamped with their due cycle; a negedge monitor pops and compares.
module tb_alu_writeback_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [4:0] ALUControl = 5'h00;
   logic [7:0] ALUResult = 8'h00;
   logic [7:0] ALUResult2 = 8'h00;
   logic [3:0] ALUFlags = 4'h0;
   logic [2:0] rd_a = 3'd0;
   logic [2:0] rd_b = 3'd0;
   logic [3:0] cond = 4'h0;
   logic       rf_we;
   logic [2:0] rf_waddr;
   logic [7:0] rf_wdata;
   logic [3:0] flags_q;
   logic       branch_taken;
   logic [7:0] branch_target;

   alu_writeback_unit #(.DATA_W(8), .REG_AW(3)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .ALUControl(ALUControl), .ALUResult(ALUResult), .ALUResult2(ALUResult2),
      .ALUFlags(ALUFlags), .rd_a(rd_a), .rd_b(rd_b), .cond(cond),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .flags_q(flags_q),
      .branch_taken(branch_taken), .branch_target(branch_target)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [31:0] cyc; logic [2:0] a; logic [7:0] d; } wr_t;
   typedef struct packed { logic [31:0] cyc; logic [7:0] t; } br_t;
   typedef struct packed { logic [31:0] cyc; logic [3:0] f; logic r; } fl_t;

   wr_t wq[$];
   br_t bq[$];
   fl_t fq[$];

   logic [31:0] cyc = 32'd0;
   int          errors = 0;
   int          checks = 0;
   logic [3:0]  m_flags = 4'h0;
   logic [2:0]  mon_a = 3'd0;
   logic [7:0]  mon_d = 8'h00;
   logic [7:0]  mon_t = 8'h00;
   logic [3:0]  mon_f = 4'h0;

   always @(posedge clk) cyc <= cyc + 32'd1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
      bit n = f[3], z = f[2], c = f[1], v = f[0];
      case (cc)
         4'h0: return 1'b1;
         4'h1: return z;
         4'h2: return !z;
         4'h3: return c;
         4'h4: return !c;
         4'h5: return n;
         4'h6: return !n;
         4'h7: return v;
         4'h8: return !v;
         4'h9: return n == v;
         4'hA: return n != v;
         4'hB: return !z && (n == v);
         4'hC: return z || (n != v);
         default: return 1'b0;
      endcase
   endfunction

   task automatic push_write(input logic [31:0] c, input logic [2:0] a, input logic [7:0] d);
      wr_t e;
`ifdef WB_R0_PROTECT_EN
      if (a == 3'd0) return;
`endif
      e.cyc = c; e.a = a; e.d = d;
      wq.push_back(e);
   endtask

   // Reference model: effects of one instruction accepted on edge ac are visible during cycle ac.
   task automatic model(input logic [4:0] op, input logic [7:0] r, input logic [7:0] r2,
                        input logic [3:0] f, input logic [2:0] a, input logic [2:0] b,
                        input logic [3:0] c, input logic [31:0] ac);
      br_t be;
      fl_t fe;
      if (!(op inside {5'h00, 5'h14, 5'h1F})) push_write(ac, a, r);
      if (op == 5'h07) push_write(ac + 32'd1, b, r2);
      if (op == 5'h1F && cond_ok(c, m_flags)) begin
         be.cyc = ac; be.t = r;
         bq.push_back(be);
      end
      if (op inside {[5'h01:5'h05], [5'h09:5'h10], 5'h14}) m_flags = f;
      fe.cyc = ac; fe.f = m_flags; fe.r = (op != 5'h07);
      fq.push_back(fe);
      if (op == 5'h07) begin
         fe.cyc = ac + 32'd1; fe.r = 1'b1;
         fq.push_back(fe);
      end
   endtask

   // Monitor: compares every observable output each cycle against the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (wq.size() > 0 && wq[0].cyc == cyc) begin
            wr_t e;
            e = wq.pop_front();
            chk("wr_we", 32'(rf_we), 32'd1);
            chk("wr_addr", 32'(rf_waddr), 32'(e.a));
            chk("wr_data", 32'(rf_wdata), 32'(e.d));
            mon_a = e.a; mon_d = e.d;
         end else begin
            chk("idle_we", 32'(rf_we), 32'd0);
            chk("hold_addr", 32'(rf_waddr), 32'(mon_a));
            chk("hold_data", 32'(rf_wdata), 32'(mon_d));
         end
         if (bq.size() > 0 && bq[0].cyc == cyc) begin
            br_t e;
            e = bq.pop_front();
            chk("br_taken", 32'(branch_taken), 32'd1);
            chk("br_target", 32'(branch_target), 32'(e.t));
            mon_t = e.t;
         end else begin
            chk("br_idle", 32'(branch_taken), 32'd0);
            chk("br_hold", 32'(branch_target), 32'(mon_t));
         end
         if (fq.size() > 0 && fq[0].cyc == cyc) begin
            fl_t e;
            e = fq.pop_front();
            mon_f = e.f;
            chk("in_ready", 32'(in_ready), 32'(e.r));
         end
         chk("flags", 32'(flags_q), 32'(mon_f));
      end
   end

   task automatic issue(input logic [4:0] op, input logic [7:0] r, input logic [7:0] r2,
                        input logic [3:0] f, input logic [2:0] a, input logic [2:0] b,
                        input logic [3:0] c, input int linger);
      int budget = 0;
      @(negedge clk);
      ALUControl = op; ALUResult = r; ALUResult2 = r2; ALUFlags = f;
      rd_a = a; rd_b = b; cond = c; in_valid = 1'b1;
      while (!in_ready && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      model(op, r, r2, f, a, b, c, cyc + 32'd1);
      @(posedge clk);
      repeat (linger) @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         ALUControl = 5'($urandom); ALUResult = 8'($urandom); rd_a = 3'($urandom);
      end
   endtask

   task automatic clear_model();
      wq.delete(); bq.delete(); fq.delete();
      m_flags = 4'h0; mon_a = 3'd0; mon_d = 8'h00; mon_t = 8'h00; mon_f = 4'h0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_we"}, 32'(rf_we), 32'd0);
      chk({tag, "_waddr"}, 32'(rf_waddr), 32'd0);
      chk({tag, "_wdata"}, 32'(rf_wdata), 32'd0);
      chk({tag, "_flags"}, 32'(flags_q), 32'd0);
      chk({tag, "_taken"}, 32'(branch_taken), 32'd0);
      chk({tag, "_target"}, 32'(branch_target), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] op;
      int sel;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", 32'(in_ready), 32'd1);

      issue(5'h01, 8'h80, 8'h00, 4'b1000, 3'd3, 3'd0, 4'h0, 0);
      idle(2);
      issue(5'h07, 8'h11, 8'h22, 4'b0110, 3'd1, 3'd2, 4'h0, 1);
      idle(2);
      issue(5'h14, 8'h99, 8'h00, 4'b0100, 3'd6, 3'd0, 4'h0, 0);
      issue(5'h1F, 8'h40, 8'h00, 4'b1111, 3'd0, 3'd0, 4'h1, 0);
      issue(5'h14, 8'h99, 8'h00, 4'b0100, 3'd6, 3'd0, 4'h0, 0);
      issue(5'h1F, 8'h41, 8'h00, 4'b0000, 3'd0, 3'd0, 4'h2, 0);
      idle(1);
      issue(5'h01, 8'h05, 8'h00, 4'b0010, 3'd7, 3'd0, 4'h0, 0);
      issue(5'h06, 8'h5A, 8'h00, 4'b1111, 3'd4, 3'd0, 4'h0, 0);
      issue(5'h1F, 8'h77, 8'h00, 4'b0000, 3'd0, 3'd0, 4'h3, 0);
      issue(5'h11, 8'hC3, 8'h00, 4'b1010, 3'd2, 3'd0, 4'h0, 0);
      idle(1);
      issue(5'h07, 8'hA1, 8'hB2, 4'b0000, 3'd0, 3'd5, 4'h0, 0);
      idle(3);

      // Reset asserted during the XCHG second-write cycle.
      issue(5'h07, 8'h33, 8'h44, 4'b0000, 3'd3, 3'd6, 4'h0, 0);
      #1;
      rst_n = 1'b0;
      in_valid = 1'b0;
      clear_model();
      #1;
      check_all_zero("rst_mid");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("ready_after_mid_reset", 32'(in_ready), 32'd1);
      idle(4);

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
         sel = $urandom_range(0, 9);
         if (sel < 3) op = 5'h1F;
         else if (sel == 3) op = 5'h07;
         else if (sel == 4) op = 5'h14;
         else op = 5'($urandom_range(0, 31));
         issue(op, 8'($urandom), 8'($urandom), 4'($urandom), 3'($urandom), 3'($urandom),
               4'($urandom), 0);
      end
      idle(5);
      chk("wq_drained", 32'(wq.size()), 32'd0);
      chk("bq_drained", 32'(bq.size()), 32'd0);
      chk("fq_drained", 32'(fq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
